// File: rtl/jtframe_sdram_pkg.sv
// jtframe_sdram_pkg: shared sizes and types for the SDRAM bank scheduler
package jtframe_sdram_pkg;
   localparam int SDRAMW_DEF = 22;
   localparam int NBANKS     = 4;
   typedef enum logic {GAME, PROG} owner_t;
   typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/jtframe_rr_pick.sv
// jtframe_rr_pick: combinational 4-way round-robin picker starting at ptr
module jtframe_rr_pick
   import jtframe_sdram_pkg::*;
(
   input  logic [NBANKS-1:0] req,
   input  logic [1:0]        ptr,
   output logic              gnt_valid,
   output logic [1:0]        gnt_idx
);
   // scan from the farthest offset back so the nearest request at or after ptr wins
   always_comb begin
      gnt_valid = |req;
      gnt_idx   = ptr;
      for (int k = NBANKS-1; k >= 0; k--)
         if (req[ptr + 2'(k)]) gnt_idx = ptr + 2'(k);
   end
endmodule

// File: rtl/jtframe_bank_sched.sv
// jtframe_bank_sched: schedules four game banks plus the download channel onto one SDRAM command port
module jtframe_bank_sched
   import jtframe_sdram_pkg::*;
#(
   parameter int SDRAMW = SDRAMW_DEF,
   parameter bit BA0_WR = 1'b1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 downloading,
   input  logic [4*SDRAMW-1:0]  ba_addr,
   input  logic [NBANKS-1:0]    ba_rd,
   input  logic [NBANKS-1:0]    ba_wr,
   input  logic [15:0]          ba0_din,
   input  logic [1:0]           ba0_din_m,
   output logic [NBANKS-1:0]    ba_ack,
   output logic [NBANKS-1:0]    ba_dst,
   output logic [NBANKS-1:0]    ba_dok,
   output logic [NBANKS-1:0]    ba_rdy,
   input  logic [SDRAMW-1:0]    prog_addr,
   input  logic [1:0]           prog_ba,
   input  logic                 prog_rd,
   input  logic                 prog_we,
   input  logic [15:0]          prog_data,
   input  logic [1:0]           prog_mask,
   output logic                 prog_ack,
   output logic                 prog_dst,
   output logic                 prog_dok,
   output logic                 prog_rdy,
   output logic                 cmd_req,
   output logic [1:0]           cmd_ba,
   output logic [SDRAMW-1:0]    cmd_addr,
   output logic                 cmd_wr,
   output logic [15:0]          cmd_din,
   output logic [1:0]           cmd_mask,
   input  logic                 cmd_ack,
   input  logic [1:0]           rsp_ba,
   input  logic                 rsp_dst,
   input  logic                 rsp_dok,
   input  logic                 rsp_rdy
);
   state_t            state, state_nxt;
   owner_t            owner [NBANKS];
   owner_t            cmd_own;
   logic [NBANKS-1:0] busy, greq;
   logic [1:0]        rr, gnt_idx, win_ba;
   logic [SDRAMW-1:0] win_addr;
   logic              gnt_valid, prog_el, load, grant, win_wr, hit, to_prog, unused_wr;

   assign unused_wr = ^ba_wr[3:1];
   assign prog_el   = (prog_we | prog_rd) & ~busy[prog_ba];

   // game banks compete only while idle and outside a download; only bank 0 may write
   always_comb begin
      for (int n = 0; n < NBANKS; n++) greq[n] = ba_rd[n] & ~busy[n] & ~downloading;
      greq[0] = (ba_rd[0] | (BA0_WR & ba_wr[0])) & ~busy[0] & ~downloading;
   end

   jtframe_rr_pick u_pick (
      .req       (greq),
      .ptr       (rr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // download always beats the game banks; writes beat reads on bank 0
   always_comb begin
      win_ba   = prog_el ? prog_ba : gnt_idx;
      win_addr = prog_el ? prog_addr : ba_addr[gnt_idx*SDRAMW +: SDRAMW];
      win_wr   = prog_el ? prog_we : (gnt_idx == 2'd0) & BA0_WR & ba_wr[0];
   end

   // next state: load a winner from IDLE, drop the command once the controller takes it
   always_comb begin
      load      = (state == IDLE) & (prog_el | gnt_valid);
      grant     = (state == ISSUE) & cmd_ack;
      state_nxt = load ? ISSUE : grant ? IDLE : state;
   end

   // command register, held stable for as long as cmd_req is up
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cmd_req  <= 1'b0;
         cmd_ba   <= '0;
         cmd_addr <= '0;
         cmd_wr   <= 1'b0;
         cmd_din  <= '0;
         cmd_mask <= '0;
         cmd_own  <= GAME;
      end else begin
         state <= state_nxt;
         if (load) begin
            cmd_req  <= 1'b1;
            cmd_ba   <= win_ba;
            cmd_addr <= win_addr;
            cmd_wr   <= win_wr;
            cmd_din  <= prog_el ? prog_data : ba0_din;
            cmd_mask <= prog_el ? prog_mask : ba0_din_m;
            cmd_own  <= prog_el ? PROG : GAME;
         end else if (grant) cmd_req <= 1'b0;
      end
   end

   // per-bank bookkeeping; a new grant overrides a completion on the same bank
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
         rr   <= '0;
         for (int n = 0; n < NBANKS; n++) owner[n] <= GAME;
      end else begin
         if (rsp_rdy & busy[rsp_ba]) busy[rsp_ba] <= 1'b0;
         if (grant) begin
            busy[cmd_ba]  <= 1'b1;
            owner[cmd_ba] <= cmd_own;
            if (cmd_own == GAME) rr <= cmd_ba + 2'd1;
         end
      end
   end

   // acks and responses go straight back to whoever owns the bank; idle banks drop responses
   always_comb begin
      hit      = busy[rsp_ba];
      to_prog  = owner[rsp_ba] == PROG;
      ba_ack   = (grant & (cmd_own == GAME)) ? NBANKS'(1) << cmd_ba : '0;
      prog_ack = grant & (cmd_own == PROG);
      ba_dst   = (rsp_dst & hit & ~to_prog) ? NBANKS'(1) << rsp_ba : '0;
      ba_dok   = (rsp_dok & hit & ~to_prog) ? NBANKS'(1) << rsp_ba : '0;
      ba_rdy   = (rsp_rdy & hit & ~to_prog) ? NBANKS'(1) << rsp_ba : '0;
      prog_dst = rsp_dst & hit & to_prog;
      prog_dok = rsp_dok & hit & to_prog;
      prog_rdy = rsp_rdy & hit & to_prog;
   end
endmodule

// File: doc/jtframe_bank_sched.md
Name: jtframe_bank_sched

Overview:
- Schedules the four SDRAM bank request channels from the game core, plus the ROM-download (prog) channel, onto one command port of the SDRAM controller.
- Sits between the game core / downloader and the SDRAM controller inside the frame.
- Arbitrates round-robin between banks, allows one outstanding access per bank, and routes controller responses (dst/dok/rdy) back to the owner of each bank.
- During download only the prog channel is served.

Parameters:
SDRAMW, 22, SDRAM word-address width (23 for 64 MB builds)
BA0_WR, 1, bank 0 accepts writes; 0 = bank 0 read-only

Ports:
clk  in  1  system/SDRAM clock
rst  in  1  reset, asynchronous, active-high
downloading  in  1  ROM download in progress
ba_addr  in  4*SDRAMW  bank addresses, bank n at [n*SDRAMW +: SDRAMW]
ba_rd  in  4  per-bank read request, level, held until ack
ba_wr  in  4  per-bank write request; only bit 0 honoured, bits 3:1 ignored
ba0_din  in  16  bank 0 write data
ba0_din_m  in  2  bank 0 write byte mask, active-high = keep byte
ba_ack  out  4  request accepted pulse
ba_dst  out  4  data start pulse
ba_dok  out  4  data valid
ba_rdy  out  4  access complete pulse
prog_addr  in  SDRAMW  download address
prog_ba  in  2  download bank
prog_rd  in  1  download read-back request
prog_we  in  1  download write request
prog_data  in  16  download data
prog_mask  in  2  download byte mask
prog_ack, prog_dst, prog_dok, prog_rdy  out  1 each  prog-channel handshake
cmd_req  out  1  command valid to controller
cmd_ba  out  2  command bank
cmd_addr  out  SDRAMW  command address
cmd_wr  out  1  write command
cmd_din  out  16  write data
cmd_mask  out  2  write mask
cmd_ack  in  1  controller accepted command
rsp_ba  in  2  bank of current response
rsp_dst, rsp_dok, rsp_rdy  in  1 each  controller response strobes

Behaviour:
- Reset: all outputs 0; busy[3:0]=0; owner[3:0]=GAME; rr pointer=0; FSM=IDLE. Reset mid-access abandons everything; no rdy is ever issued for that access.
- Eligibility:
  - Game bank n is eligible when (ba_rd[n] | (n==0 & BA0_WR & ba_wr[0])), !busy[n] and !downloading.
  - Prog is eligible when (prog_we | prog_rd) and !busy[prog_ba].
  - If prog is eligible it always wins. Otherwise the first eligible bank at or after the rr pointer (modulo 4) wins.
- FSM IDLE:
  - Winner chosen in cycle n; cmd_* registered, cmd_req=1 in cycle n+1.
  - cmd_wr=1 for prog_we, or for bank 0 with ba_wr[0] and BA0_WR. A write request takes precedence over a simultaneous rd on bank 0.
  - Go to ISSUE.
- FSM ISSUE:
  - cmd_* held stable while cmd_req=1.
  - On cmd_ack: cmd_req=0 next cycle; busy[ba]=1; owner[ba]=PROG or GAME; the owner's ack pulses in the same cycle as cmd_ack (combinational route).
  - rr pointer = granted bank+1, only on game grants. Return to IDLE.
  - Minimum spacing between grants is 2 cycles.
- Responses: rsp_dst/dok/rdy are routed to ba_*[rsp_ba] or prog_* according to owner[rsp_ba], combinationally, same cycle. rsp_rdy clears busy[rsp_ba] on the next edge; that bank is eligible again in the following cycle, never in the same cycle.
- A response for a bank with busy=0 is dropped and produces no output pulse.
- downloading rises with game accesses outstanding: they complete and route to the game side; no new game grants. A game cmd already in ISSUE still completes normally.
- downloading falls with a prog access outstanding: it completes and routes to prog_*.
- A requester deasserting before ack: the request is withdrawn only while in IDLE. Once cmd_req=1 the command is committed.
- Simultaneous cmd_ack and rsp_rdy on the same bank is legal: the busy bit ends set (new grant wins).

Decomposition:
- Package jtframe_sdram_pkg: SDRAMW default; NBANKS=4; typedef owner_t {GAME, PROG}; typedef state_t {IDLE, ISSUE}.
- One sub-module: jtframe_rr_pick, a combinational 4-way round-robin picker (req[3:0], ptr[1:0] -> gnt_valid, gnt_idx[1:0]).

Test Plan:
1. ba_rd=4'b1111 held, cmd_ack 1 cycle after each cmd_req, rsp_rdy 8 cycles later -> grants in order 0,1,2,3. No second bank-0 grant before its rsp_rdy.
2. Bank 0 write: ba_wr[0]=1, ba0_din=16'hA55A, ba0_din_m=2'b01 -> cmd_wr=1, cmd_din=A55A, cmd_mask=01, ba_ack[0] coincident with cmd_ack. Same with BA0_WR=0 -> no grant.
3. downloading=1, prog_we=1, prog_ba=2, ba_rd[2]=1 -> prog granted, prog_ack pulses, ba_ack[2] stays 0. After downloading=0 and prog_rdy, bank 2 is granted to the game.
4. Game bank-1 access outstanding when downloading rises -> rsp_dst/dok/rdy with rsp_ba=1 appear on ba_dst[1]/ba_dok[1]/ba_rdy[1], not on prog_*.
5. rst asserted while cmd_req=1 and busy=4'b0101 -> all outputs 0 immediately. A later rsp_rdy with rsp_ba=0 is dropped.
6. rsp_rdy for bank 3 in the same cycle ba_rd[3] is pending -> bank 3 is not granted in that cycle; cmd_req for bank 3 appears 2 cycles later.
